stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Shares one LIFO stack instance between two requesters, A and B.
- Each requester issues push or pop transactions through a req/ack handshake.
- The block arbitrates round-robin and drives the stack's single-cycle push/pop strobes.
- It returns pop data or an error flag to the winner; it sits between debounced/user-side request logic and the stack unit.

Parameters:
- DATA_SIZE, 3, width of stack data words and of all data ports.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset=0 resets on next clk edge).
- a_req  input  1  requester A transaction request (level, held until a_ack).
- a_op  input  1  A operation: 0=push, 1=pop; stable while a_req=1.
- a_wdata  input  DATA_SIZE  A push data; stable while a_req=1.
- a_ack  output  1  one-cycle pulse: A transaction complete.
- a_rdata  output  DATA_SIZE  A pop result; updated only on A pop ack with err=0.
- a_err  output  1  A rejected (push when full / pop when empty); updated on every A ack.
- b_req, b_op, b_wdata, b_ack, b_rdata, b_err  same as A ports, for requester B.
- stack_full  input  1  stack full flag.
- stack_empty  input  1  stack empty flag.
- stack_top_data  input  DATA_SIZE  current top-of-stack word (valid when not empty).
- stack_push  output  1  one-cycle push strobe to stack.
- stack_pop  output  1  one-cycle pop strobe to stack.
- stack_push_data  output  DATA_SIZE  data accompanying stack_push.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (reset=0 at clk edge):
  - FSM to IDLE; last_grant pointer = B, so A wins the first tie.
  - All outputs 0, including rdata/err registers and stack strobes.
  - Any in-flight transaction is abandoned with no strobe and no ack; the requester must re-request.
- FSM has three states: IDLE, ISSUE, ACK.
- IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, grant it.
  - If both are high, grant the one not equal to last_grant.
  - On grant: register gnt_id, op and wdata; update last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - Push with stack_full=0: stack_push=1, stack_push_data=latched wdata.
  - Pop with stack_empty=0: stack_pop=1; capture stack_top_data into the granted rdata register at this edge.
  - Push with full, or pop with empty: no strobe; set pending err=1.
  - Always go to ACK.
- ACK (exactly one cycle):
  - Granted requester's ack=1; its err register is loaded with the pending err.
  - Return to IDLE.
- stack_push and stack_pop:
  - Decoded from the registered state and latched op only.
  - Never both high; high only in ISSUE.
- Latency: req sampled high in IDLE at edge N, strobe in cycle N+1, ack in cycle N+2.
  - Back-to-back service: next grant sampled at the edge ending ACK's following IDLE cycle, so a new strobe can occur at most once every 3 cycles.
- Handshake rules:
  - Requester must deassert req in the cycle after its ack, or it is treated as a new transaction.
  - req is never dropped by the requester before ack.
  - Non-granted requester's req is held pending with no timeout.
- Fairness: with both requesters continuously requesting, grants alternate A,B,A,B.
- rdata and err hold their value between acks.
- The other requester's outputs never change during a transaction that is not its own.
- No combinational path from a_req/b_req to any output.

Test Plan:
- Reset with reset=0 for 2 cycles → all outputs 0, busy=0; first simultaneous a_req/b_req afterwards grants A.
- A push 3'b101 into empty stack → stack_push=1 exactly 1 cycle after req sampled, stack_push_data=5, a_ack 2 cycles after, a_err=0; b_* outputs unchanged.
- B pop after A pushes 1,2,3 → b_rdata=3, b_err=0, stack_pop pulses once.
- Both requesters issue back-to-back push transactions → grants alternate A,B,A,B.
- Both requesters hold req continuously → 4 pushes fill the stack (depth 4); the 5th push gets err=1 with no stack_push pulse.
- Pop on empty stack → err=1, no stack_pop pulse, rdata keeps its previous value.
- reset=0 asserted during ISSUE of a push → no ack issued; after release, busy=0, the stack strobe is seen at most in that single ISSUE cycle, and the next tie grants A.

Source files
------------

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between requesters A and B.
// Each grant runs IDLE -> ISSUE (stack strobe) -> ACK (one-cycle ack to the winner).
module stack_arbiter #(
    parameter int DATA_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic                 a_op,
    input  logic [DATA_SIZE-1:0] a_wdata,
    output logic                 a_ack,
    output logic [DATA_SIZE-1:0] a_rdata,
    output logic                 a_err,
    input  logic                 b_req,
    input  logic                 b_op,
    input  logic [DATA_SIZE-1:0] b_wdata,
    output logic                 b_ack,
    output logic [DATA_SIZE-1:0] b_rdata,
    output logic                 b_err,
    input  logic                 stack_full,
    input  logic                 stack_empty,
    input  logic [DATA_SIZE-1:0] stack_top_data,
    output logic                 stack_push,
    output logic                 stack_pop,
    output logic [DATA_SIZE-1:0] stack_push_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_gnt_b;
    logic                   r_last_b;
    logic                   r_op;
    logic [DATA_SIZE-1:0]   r_wdata;
    logic [DATA_SIZE-1:0]   r_a_rdata;
    logic [DATA_SIZE-1:0]   r_b_rdata;
    logic                   r_a_err;
    logic                   r_b_err;
    logic                   w_any;
    logic                   w_pick_b;
    logic                   w_err;

    assign w_any    = a_req | b_req;
    // On a tie the requester that did not win last time is served.
    assign w_pick_b = (a_req & b_req) ? ~r_last_b : b_req;
    assign w_err    = r_op ? stack_empty : stack_full;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gnt_b   <= 1'b0;
            r_last_b  <= 1'b1;
            r_op      <= 1'b0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_a_err   <= 1'b0;
            r_b_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt_b  <= w_pick_b;
                r_last_b <= w_pick_b;
                r_op     <= w_pick_b ? b_op : a_op;
                r_wdata  <= w_pick_b ? b_wdata : a_wdata;
            end
            // Result registers settle at the ISSUE edge so they are valid alongside ack.
            if (r_state == ISSUE) begin
                if (r_gnt_b) begin
                    r_b_err <= w_err;
                    if (r_op && !stack_empty) r_b_rdata <= stack_top_data;
                end else begin
                    r_a_err <= w_err;
                    if (r_op && !stack_empty) r_a_rdata <= stack_top_data;
                end
            end
        end
    end

    always_comb begin
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        a_ack      = 1'b0;
        b_ack      = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            ISSUE: begin
                stack_push = ~r_op & ~stack_full;
                stack_pop  =  r_op & ~stack_empty;
            end
            ACK: begin
                a_ack = ~r_gnt_b;
                b_ack =  r_gnt_b;
            end
            default: ;
        endcase
    end

    assign stack_push_data = r_wdata;
    assign a_rdata         = r_a_rdata;
    assign a_err           = r_a_err;
    assign b_rdata         = r_b_rdata;
    assign b_err           = r_b_err;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: depth-4 stack model, directed requests, scoreboard-checked acks.
module tb_stack_arbiter;
    localparam int DW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          a_req = 0, a_op = 0, b_req = 0, b_op = 0;
    logic [DW-1:0] a_wdata = 0, b_wdata = 0;
    logic          a_ack, a_err, b_ack, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          stack_full, stack_empty, stack_push, stack_pop, busy;
    logic [DW-1:0] stack_top_data, stack_push_data;

    stack_arbiter #(.DATA_SIZE(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_top_data(stack_top_data),
        .stack_push(stack_push), .stack_pop(stack_pop), .stack_push_data(stack_push_data),
        .busy(busy)
    );

    // Depth-4 stack model driven by the DUT strobes
    logic [DW-1:0] stk [4];
    logic [2:0]    cnt = 0;
    logic          clr_stk = 0;
    always @(posedge clk) begin
        if (clr_stk) cnt <= 0;
        else if (stack_push && cnt < 4) begin
            stk[cnt[1:0]] <= stack_push_data;
            cnt <= cnt + 3'd1;
        end else if (stack_pop && cnt > 0) cnt <= cnt - 3'd1;
    end
    assign stack_full     = (cnt == 3'd4);
    assign stack_empty    = (cnt == 3'd0);
    assign stack_top_data = (cnt != 0) ? stk[cnt[1:0] - 2'd1] : '0;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic          who;
        logic          op;
        logic          err;
        logic [DW-1:0] rd;
    } exp_t;
    exp_t sbq[$];

    task automatic expect_txn(input logic who, input logic op, input logic err, input logic [DW-1:0] rd);
        exp_t e;
        e.who = who; e.op = op; e.err = err; e.rd = rd;
        sbq.push_back(e);
    endtask

    // Monitor: expected output registers of both requesters, updated only from the scoreboard
    logic [DW-1:0] m_ard = 0, m_brd = 0;
    logic          m_aerr = 0, m_berr = 0;
    logic          rst_seen = 0;
    int            push_cnt = 0, pop_cnt = 0;
    exp_t          m_e;
    always @(posedge clk) rst_seen <= ~reset;
    always @(negedge clk) begin
        if (rst_seen) begin
            m_ard = 0; m_brd = 0; m_aerr = 0; m_berr = 0;
        end else if (a_ack || b_ack) begin
            check("ack_onehot", int'(a_ack & b_ack), 0);
            check("sb_nonempty", int'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                m_e = sbq.pop_front();
                check("grant_who", int'(b_ack), int'(m_e.who));
                if (m_e.who) begin
                    if (m_e.op && !m_e.err) m_brd = m_e.rd;
                    m_berr = m_e.err;
                end else begin
                    if (m_e.op && !m_e.err) m_ard = m_e.rd;
                    m_aerr = m_e.err;
                end
            end
            check("a_rdata", int'(a_rdata), int'(m_ard));
            check("a_err", int'(a_err), int'(m_aerr));
            check("b_rdata", int'(b_rdata), int'(m_brd));
            check("b_err", int'(b_err), int'(m_berr));
        end
        if (stack_push || stack_pop) begin
            check("strobe_excl", int'(stack_push & stack_pop), 0);
            if (stack_push) push_cnt++;
            else            pop_cnt++;
        end
    end

    task automatic drive(input logic who, input logic op, input logic [DW-1:0] wd);
        logic got;
        got = 0;
        if (who) begin b_op = op; b_wdata = wd; b_req = 1; end
        else     begin a_op = op; a_wdata = wd; a_req = 1; end
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            got = who ? b_ack : a_ack;
        end
        check("ack_seen", int'(got), 1);
        if (who) b_req = 0;
        else     a_req = 0;
    endtask

    task automatic clear_stack();
        clr_stk = 1;
        @(posedge clk); #1;
        clr_stk = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int p;
    initial begin
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", int'({a_ack, b_ack, a_err, b_err, a_rdata, b_rdata,
                                stack_push, stack_pop, stack_push_data}), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1;
        clear_stack();

        // A push 5: strobe one cycle after sampling, ack one cycle later
        p = push_cnt;
        expect_txn(0, 0, 0, 0);
        a_op = 0; a_wdata = 3'd5; a_req = 1;
        @(posedge clk); #1;
        check("t2_push", int'(stack_push), 1);
        check("t2_pdata", int'(stack_push_data), 5);
        check("t2_noack_yet", int'(a_ack), 0);
        check("t2_busy", int'(busy), 1);
        @(posedge clk); #1;
        check("t2_ack", int'(a_ack), 1);
        check("t2_err", int'(a_err), 0);
        check("t2_push_off", int'(stack_push), 0);
        a_req = 0;
        @(posedge clk); #1;
        check("t2_push_cnt", push_cnt - p, 1);
        check("t2_idle", int'(busy), 0);

        // A pushes 1,2,3 then B pops 3
        clear_stack();
        for (int i = 1; i <= 3; i++) begin
            expect_txn(0, 0, 0, 0);
            drive(0, 0, 3'(i));
        end
        p = pop_cnt;
        expect_txn(1, 1, 0, 3'd3);
        drive(1, 1, 0);
        @(posedge clk); #1;
        check("t3_pop_cnt", pop_cnt - p, 1);
        check("t3_brd", int'(b_rdata), 3);

        // Both requesting continuously: A1 B4 A2 B5 fill the stack, A3 hits full
        clear_stack();
        p = push_cnt;
        expect_txn(0, 0, 0, 0);
        expect_txn(1, 0, 0, 0);
        expect_txn(0, 0, 0, 0);
        expect_txn(1, 0, 0, 0);
        expect_txn(0, 0, 1, 0);
        fork
            begin drive(0, 0, 3'd1); drive(0, 0, 3'd2); drive(0, 0, 3'd3); end
            begin drive(1, 0, 3'd4); drive(1, 0, 3'd5); end
        join
        @(posedge clk); #1;
        check("t4_push_cnt", push_cnt - p, 4);
        check("t4_a_err", int'(a_err), 1);

        // Drain in LIFO order, then pop on empty keeps rdata
        p = pop_cnt;
        expect_txn(1, 1, 0, 3'd5); drive(1, 1, 0);
        expect_txn(0, 1, 0, 3'd2); drive(0, 1, 0);
        expect_txn(1, 1, 0, 3'd4); drive(1, 1, 0);
        expect_txn(0, 1, 0, 3'd1); drive(0, 1, 0);
        expect_txn(0, 1, 1, 0);    drive(0, 1, 0);
        @(posedge clk); #1;
        check("t6_pop_cnt", pop_cnt - p, 4);
        check("t6_a_rd_kept", int'(a_rdata), 1);
        check("t6_a_err", int'(a_err), 1);

        // Reset during ISSUE of a push abandons it
        clear_stack();
        p = push_cnt;
        a_op = 0; a_wdata = 3'd7; a_req = 1;
        @(posedge clk); #1;
        check("t7_issue_push", int'(stack_push), 1);
        reset = 0;
        @(posedge clk); #1;
        a_req = 0;
        check("t7_no_ack", int'(a_ack | b_ack), 0);
        check("t7_busy", int'(busy), 0);
        check("t7_outs", int'({a_err, a_rdata, b_err, b_rdata, stack_push, stack_pop}), 0);
        reset = 1;
        @(posedge clk); #1;
        check("t7_push_once", push_cnt - p, 1);
        check("t7_idle", int'(busy), 0);
        expect_txn(0, 0, 0, 0);
        expect_txn(1, 0, 0, 0);
        fork
            drive(0, 0, 3'd6);
            drive(1, 0, 3'd4);
        join

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
